// File: rtl/uart_tx_arbiter_if.sv
// Request/transmit bundle between the button edge detectors, the arbiter and the UART TX core.
// The arbiter uses the slave modport; the requester/UART side uses master.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
);
   localparam int GRANT_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        i_req_pulse;
   logic [NUM_REQ*DATA_W-1:0] i_req_data;
   logic                      o_tx_start;
   logic [DATA_W-1:0]         o_tx_data;
   logic                      i_tx_busy;
   logic [GRANT_W-1:0]        o_grant_id;
   logic [NUM_REQ-1:0]        o_pending;
   logic                      o_drop;
   logic                      o_timeout;

   modport master (
      output i_req_pulse, i_req_data, i_tx_busy,
      input  o_tx_start, o_tx_data, o_grant_id, o_pending, o_drop, o_timeout
   );

   modport slave (
      input  i_req_pulse, i_req_data, i_tx_busy,
      output o_tx_start, o_tx_data, o_grant_id, o_pending, o_drop, o_timeout
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ button requesters.
// Latches request pulses and bytes, grants one requester at a time and runs the start/busy handshake.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_W       = 8,
   parameter int BUSY_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   uart_tx_arbiter_if.slave  bus
);
   localparam int GRANT_W = $clog2(NUM_REQ);
   localparam int CNT_W   = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

   state_t              state;
   state_t              state_next;
   logic [NUM_REQ-1:0]  pending;
   logic [DATA_W-1:0]   data_q [NUM_REQ];
   logic [GRANT_W-1:0]  last_grant;
   logic [GRANT_W-1:0]  grant_id;
   logic [DATA_W-1:0]   tx_data;
   logic [CNT_W-1:0]    busy_cnt;
   logic                drop_q;
   logic                timeout_q;

   logic [GRANT_W-1:0]  sel;
   logic [GRANT_W-1:0]  idx;
   logic                sel_valid;
   logic                grant;
   logic [NUM_REQ-1:0]  grant_mask;
   logic                tx_start;
   logic                busy_expired;
   logic                timeout_hit;
   logic                count_en;

   // Search begins one past the last grant so every requester gets a turn.
   always_comb begin
      sel       = '0;
      idx       = '0;
      sel_valid = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = GRANT_W'((int'(last_grant) + i) % NUM_REQ);
         if (!sel_valid && pending[idx]) begin
            sel       = idx;
            sel_valid = 1'b1;
         end
      end
   end

   assign busy_expired = (busy_cnt == CNT_W'(BUSY_TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (|pending)         state_next = START;
         START:                           state_next = WAIT_BUSY;
         WAIT_BUSY: if (bus.i_tx_busy)    state_next = WAIT_DONE;
                    else if (busy_expired) state_next = IDLE;
         WAIT_DONE: if (!bus.i_tx_busy)   state_next = IDLE;
         default:                         state_next = IDLE;
      endcase
   end

   always_comb begin
      tx_start    = (state == START);
      grant       = (state == IDLE) && sel_valid;
      grant_mask  = grant ? (NUM_REQ'(1) << sel) : '0;
      count_en    = (state == WAIT_BUSY) && !bus.i_tx_busy && !busy_expired;
      timeout_hit = (state == WAIT_BUSY) && !bus.i_tx_busy && busy_expired;
   end

   // A pulse on a requester being granted this cycle is a fresh request, not a duplicate.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending    <= '0;
         last_grant <= GRANT_W'(NUM_REQ - 1);
         grant_id   <= '0;
         tx_data    <= '0;
         busy_cnt   <= '0;
         drop_q     <= 1'b0;
         timeout_q  <= 1'b0;
         for (int k = 0; k < NUM_REQ; k++) data_q[k] <= '0;
      end else begin
         pending   <= (pending & ~grant_mask) | bus.i_req_pulse;
         drop_q    <= |(bus.i_req_pulse & pending & ~grant_mask);
         timeout_q <= timeout_hit;
         for (int k = 0; k < NUM_REQ; k++) begin
            if (bus.i_req_pulse[k] && (!pending[k] || grant_mask[k]))
               data_q[k] <= bus.i_req_data[k*DATA_W +: DATA_W];
         end
         if (grant) begin
            last_grant <= sel;
            grant_id   <= sel;
            tx_data    <= data_q[sel];
         end
         if (tx_start)      busy_cnt <= '0;
         else if (count_en) busy_cnt <= busy_cnt + CNT_W'(1);
      end
   end

   assign bus.o_tx_start = tx_start;
   assign bus.o_tx_data  = tx_data;
   assign bus.o_grant_id = grant_id;
   assign bus.o_pending  = pending;
   assign bus.o_drop     = drop_q;
   assign bus.o_timeout  = timeout_q;
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares a single UART transmitter between NUM_REQ button requesters. Each requester delivers single-cycle request pulses from its button edge detector, together with a byte to send. The block latches the pulse and the byte, grants the transmitter one requester at a time, and sequences the transmitter's start/busy handshake. It sits between the button edge detectors and the UART TX core.

## Interface
- NUM_REQ, default 4: number of requesters (2..8).
- DATA_W, default 8: transmit data width.
- BUSY_TIMEOUT, default 15: maximum number of cycles to wait for i_tx_busy to rise after a start.
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- i_req_pulse  input  NUM_REQ  one-cycle request pulses, bit k = requester k.
- i_req_data  input  NUM_REQ*DATA_W  byte for requester k in bits [k*DATA_W +: DATA_W], sampled with its pulse.
- o_tx_start  output  1  one-cycle start strobe to the UART TX.
- o_tx_data  output  DATA_W  byte to transmit; held stable from the start strobe until the return to IDLE.
- i_tx_busy  input  1  UART TX busy flag.
- o_grant_id  output  $clog2(NUM_REQ)  index of the currently or most recently granted requester.
- o_pending  output  NUM_REQ  latched, not-yet-granted requests.
- o_drop  output  1  one-cycle pulse: a request arrived while that requester was already pending.
- o_timeout  output  1  one-cycle pulse: the busy flag never rose within BUSY_TIMEOUT cycles.

## Operation
- Per-requester pending bit and DATA_W data register.
  - On i_req_pulse[k] with pending[k]=0, or with pending[k] being cleared by a grant in the same cycle: set pending[k] and load data[k].
  - On i_req_pulse[k] with pending[k]=1 and no grant of k in that cycle: keep the old data, leave pending set, and pulse o_drop.
- Round-robin selection.
  - The search starts at last_grant+1 and wraps modulo NUM_REQ. The first pending requester found is selected.
  - last_grant resets to NUM_REQ-1, so requester 0 has first priority after reset.
- FSM states:
  - IDLE: if o_pending≠0, go to START. The grant takes effect in this transition: last_grant and o_grant_id take the selected index, o_tx_data takes data[sel], and pending[sel] is cleared.
  - START: o_tx_start=1 for exactly this one cycle. Go to WAIT_BUSY and reset the timeout counter.
  - WAIT_BUSY: if i_tx_busy=1, go to WAIT_DONE. Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT-1 without busy, pulse o_timeout and go to IDLE. The byte is discarded and not retried.
  - WAIT_DONE: when i_tx_busy=0, go to IDLE.
- New requests, including from the requester being served, are accepted in every state.
- Reset values:
  - o_tx_start=0, o_tx_data=0, o_grant_id=0, o_pending=0, o_drop=0, o_timeout=0.
  - FSM in IDLE, counter=0, all data registers 0.
- Reset asserted mid-transfer: everything returns to its reset value immediately, and all pending requests are lost. The block does not wait for the UART to finish.

## Timing
- A pulse sampled at edge t is visible on o_pending after edge t.
- If the FSM is in IDLE, the grant happens at edge t+1: pending is cleared and o_tx_start=1 during the cycle after t+1. Minimum latency from pulse to start is 2 edges.
- o_tx_start is never high for two consecutive cycles. The minimum spacing between two start strobes is 4 cycles (START, WAIT_BUSY, WAIT_DONE, IDLE).
- o_drop and o_timeout are registered and appear one cycle after the causing edge.
- i_tx_busy is synchronous to clk. If busy rises in the START cycle, it is first acted on in WAIT_BUSY; this is tolerated.

## Test plan
- Single request:
  - Stimulus: after reset, pulse req 2 with 0x41; the TX model raises busy 1 cycle after start and holds it 10 cycles.
  - Required: o_tx_start 2 cycles after the pulse, o_tx_data=0x41, o_grant_id=2, pending=0.
- Simultaneous requests:
  - Stimulus: pulse reqs 0, 1 and 3 in the same cycle with 0x10, 0x11 and 0x13.
  - Required: starts in order 0, 1, 3 with the matching bytes. Then pulse reqs 0 and 1 together: req 1 is served first only if last_grant is 0. Check the rotation from last_grant=3, which gives order 0 then 1.
- Duplicate request:
  - Stimulus: pulse req 1 with 0x55 twice while it is pending (the FSM is busy with req 0).
  - Required: o_drop pulses once, and the byte later sent for req 1 is 0x55.
- Re-request during service:
  - Stimulus: pulse req 0 during its own WAIT_DONE with 0x77.
  - Required: pending[0] is set, and a second start follows with 0x77.
- Busy timeout:
  - Stimulus: the TX model never raises busy.
  - Required: o_timeout pulses exactly BUSY_TIMEOUT cycles after WAIT_BUSY entry, the FSM returns to IDLE, and the next pending requester is served.
- Reset mid-transfer:
  - Stimulus: assert reset during WAIT_DONE with 2 requests pending.
  - Required: all outputs are 0 during reset, no start strobe appears after release, and o_pending=0.
